// File: rtl/diff_pkg.sv
// Shared mode encodings and sizing helper for the diff_sm_pipe subtractor.
package diff_pkg;

  localparam logic [1:0] MODE_SM  = 2'd0;
  localparam logic [1:0] MODE_SAT = 2'd1;
  localparam logic [1:0] MODE_ABS = 2'd2;

  // Width that holds the sum of CH magnitudes of WIDTH bits each without overflow.
  function automatic int sumWidth(input int width, input int ch);
    return width + $clog2(ch);
  endfunction

endpackage

// File: rtl/diff_sm_lane.sv
// One channel of the subtractor: turns a registered WIDTH+1 bit raw difference
// into its magnitude and the mode-selected output word.
module diff_sm_lane
  import diff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_d,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_m,
  output logic [WIDTH:0]   o_enc
);

  logic w_neg;

  assign w_neg = i_d[WIDTH];

  // A negative difference wraps to 2^WIDTH - |a-b| in the low bits, so negate it back.
  assign o_m = w_neg ? (~i_d[WIDTH-1:0] + 1'b1) : i_d[WIDTH-1:0];

  always_comb begin
    o_enc = {w_neg, o_m};
    case (i_mode)
      MODE_SAT: o_enc = {1'b0, (w_neg ? {WIDTH{1'b0}} : o_m)};
      MODE_ABS: o_enc = {1'b0, o_m};
      default:  o_enc = {w_neg, o_m};
    endcase
  end

endmodule

// File: rtl/diff_sm_pipe.sv
// Two-stage valid/ready multi-channel subtractor with per-beat output encoding
// and a saturating sum of absolute differences released on each last beat.
module diff_sm_pipe
  import diff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 3,
  parameter int SAD_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [CH*WIDTH-1:0]     a,
  input  logic [CH*WIDTH-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [CH*(WIDTH+1)-1:0] out_data,
  output logic                    sad_valid,
  output logic [SAD_W-1:0]        sad
);

  localparam int DW    = WIDTH + 1;
  localparam int SUM_W = sumWidth(WIDTH, CH);

  logic                w_en;
  logic                w_xfer;
  logic [CH*DW-1:0]    w_diff;
  logic [CH*DW-1:0]    w_enc;
  logic [CH*WIDTH-1:0] w_mag;
  logic [SUM_W-1:0]    w_beatSum;
  logic [SAD_W:0]      w_total;
  logic [SAD_W-1:0]    w_satTotal;

  logic                r_s1Valid;
  logic                r_s1Last;
  logic [1:0]          r_s1Mode;
  logic [CH*DW-1:0]    r_s1Diff;
  logic                r_outValid;
  logic                r_outLast;
  logic [CH*DW-1:0]    r_outData;
  logic [SUM_W-1:0]    r_outSum;
  logic [SAD_W-1:0]    r_acc;
  logic [SAD_W-1:0]    r_sad;
  logic                r_sadValid;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign w_en     = !r_outValid || out_ready;
  assign in_ready = w_en && !rst;
  assign w_xfer   = r_outValid && out_ready;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    assign w_diff[k*DW +: DW] = {1'b0, a[k*WIDTH +: WIDTH]} + ~{1'b0, b[k*WIDTH +: WIDTH]} + 1'b1;

    diff_sm_lane #(.WIDTH(WIDTH)) u_lane (
      .i_d    (r_s1Diff[k*DW +: DW]),
      .i_mode (r_s1Mode),
      .o_m    (w_mag[k*WIDTH +: WIDTH]),
      .o_enc  (w_enc[k*DW +: DW])
    );
  end

  always_comb begin
    w_beatSum = '0;
    for (int k = 0; k < CH; k++) begin
      w_beatSum = w_beatSum + SUM_W'(w_mag[k*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1Mode  <= MODE_SM;
      r_s1Diff  <= '0;
    end else if (w_en) begin
      r_s1Valid <= in_valid;
      r_s1Last  <= in_last;
      r_s1Mode  <= mode;
      r_s1Diff  <= w_diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_outData  <= '0;
      r_outSum   <= '0;
    end else if (w_en) begin
      r_outValid <= r_s1Valid;
      r_outLast  <= r_s1Valid && r_s1Last;
      r_outData  <= w_enc;
      r_outSum   <= w_beatSum;
    end
  end

  assign w_total    = {1'b0, r_acc} + (SAD_W+1)'(r_outSum);
  assign w_satTotal = w_total[SAD_W] ? '1 : w_total[SAD_W-1:0];

  // The accumulator restarts at zero once a group's total has been published.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_sad      <= '0;
      r_sadValid <= 1'b0;
    end else begin
      r_sadValid <= w_xfer && r_outLast;
      if (w_xfer) begin
        if (r_outLast) begin
          r_sad <= w_satTotal;
          r_acc <= '0;
        end else begin
          r_acc <= w_satTotal;
        end
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_last  = r_outLast;
  assign out_data  = r_outData;
  assign sad_valid = r_sadValid;
  assign sad       = r_sad;

endmodule

// File: tb/tb_diff_sm_pipe.sv
// Self-checking bench for diff_sm_pipe: a default instance and a SAD_W=10 instance
// share one stimulus stream and are both compared against a behavioural model.
module tb_diff_sm_pipe;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam int DW = W + 1;
  localparam longint SAD_MAX_A = (64'd1 << 24) - 1;
  localparam longint SAD_MAX_B = (64'd1 << 10) - 1;

  typedef struct {
    logic [CH*DW-1:0] data;
    bit               last;
    int               sum;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        modeIn = 2'd0;
  logic              inValid = 1'b0;
  logic              inLast = 1'b0;
  logic [CH*W-1:0]   aIn = '0;
  logic [CH*W-1:0]   bIn = '0;
  logic              outReady = 1'b1;

  logic              inReadyA, outValidA, outLastA, sadValidA;
  logic [CH*DW-1:0]  outDataA;
  logic [23:0]       sadA;
  logic              inReadyB, outValidB, outLastB, sadValidB;
  logic [CH*DW-1:0]  outDataB;
  logic [9:0]        sadB;

  int testsRun = 0;
  int testsFailed = 0;

  beat_t      s1, s2;
  bit         s1V = 0, s2V = 0;
  longint     accA = 0, accB = 0;
  logic [23:0] expSadA = '0;
  logic [9:0]  expSadB = '0;
  bit         expSadValid = 0;

  always #5 clk = ~clk;

  diff_sm_pipe dut (
    .clk(clk), .rst(rst), .mode(modeIn), .in_valid(inValid), .in_ready(inReadyA),
    .in_last(inLast), .a(aIn), .b(bIn), .out_valid(outValidA), .out_ready(outReady),
    .out_last(outLastA), .out_data(outDataA), .sad_valid(sadValidA), .sad(sadA)
  );

  diff_sm_pipe #(.WIDTH(W), .CH(CH), .SAD_W(10)) dutSat (
    .clk(clk), .rst(rst), .mode(modeIn), .in_valid(inValid), .in_ready(inReadyB),
    .in_last(inLast), .a(aIn), .b(bIn), .out_valid(outValidB), .out_ready(outReady),
    .out_last(outLastB), .out_data(outDataB), .sad_valid(sadValidB), .sad(sadB)
  );

  // Expected output word straight from the arithmetic meaning of each mode.
  function automatic beat_t computeBeat(input logic [CH*W-1:0] av, input logic [CH*W-1:0] bv,
                                        input logic [1:0] md, input logic lst);
    beat_t r;
    int diff, mag, word;
    r.data = '0;
    r.sum  = 0;
    r.last = lst;
    for (int k = 0; k < CH; k++) begin
      diff = int'(av[k*W +: W]) - int'(bv[k*W +: W]);
      mag  = (diff < 0) ? -diff : diff;
      r.sum += mag;
      case (md)
        2'd1:    word = (diff < 0) ? 0 : mag;
        2'd2:    word = mag;
        default: word = (diff < 0) ? ((1 << W) + mag) : mag;
      endcase
      r.data[k*DW +: DW] = DW'(word);
    end
    return r;
  endfunction

  function automatic longint satAdd(input longint x, input longint y, input longint lim);
    return (x + y > lim) ? lim : x + y;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a two-slot pipe that shifts whenever its output slot is free or taken.
  always @(posedge clk) begin
    if (rst) begin
      s1V = 0;
      s2V = 0;
      accA = 0;
      accB = 0;
      expSadA = '0;
      expSadB = '0;
      expSadValid = 0;
    end else begin
      expSadValid = 0;
      if (s2V && outReady) begin
        accA = satAdd(accA, longint'(s2.sum), SAD_MAX_A);
        accB = satAdd(accB, longint'(s2.sum), SAD_MAX_B);
        if (s2.last) begin
          expSadA = 24'(accA);
          expSadB = 10'(accB);
          expSadValid = 1;
          accA = 0;
          accB = 0;
        end
      end
      if (!s2V || outReady) begin
        s2  = s1;
        s2V = s1V;
        s1V = inValid;
        s1  = computeBeat(aIn, bIn, modeIn, inLast);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("inReady", 64'(inReadyA), 64'(!rst && (!s2V || outReady)));
    checkOutput("inReadySat", 64'(inReadyB), 64'(!rst && (!s2V || outReady)));
    checkOutput("outValid", 64'(outValidA), 64'(s2V));
    checkOutput("outValidSat", 64'(outValidB), 64'(s2V));
    if (s2V) begin
      checkOutput("outData", 64'(outDataA), 64'(s2.data));
      checkOutput("outDataSat", 64'(outDataB), 64'(s2.data));
      checkOutput("outLast", 64'(outLastA), 64'(s2.last));
      checkOutput("outLastSat", 64'(outLastB), 64'(s2.last));
    end
    checkOutput("sadValid", 64'(sadValidA), 64'(expSadValid));
    checkOutput("sadValidSat", 64'(sadValidB), 64'(expSadValid));
    checkOutput("sad", 64'(sadA), 64'(expSadA));
    checkOutput("sadSat", 64'(sadB), 64'(expSadB));
  end

  task automatic applyStimulus(input logic [W-1:0] aVal, input logic [W-1:0] bVal,
                               input logic [1:0] md, input logic lst);
    inValid = 1'b1;
    aIn     = {CH{aVal}};
    bIn     = {CH{bVal}};
    modeIn  = md;
    inLast  = lst;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic directedBeat(input logic [W-1:0] aVal, input logic [W-1:0] bVal,
                              input logic [1:0] md, input logic lst, input logic [DW-1:0] expWord);
    applyStimulus(aVal, bVal, md, lst);
    @(negedge clk);
    checkOutput("latencyOneCycle", 64'(outValidA), 64'd0);
    @(negedge clk);
    checkOutput("latencyTwoCycles", 64'(outValidA), 64'd1);
    checkOutput("encodeLiteral", 64'(outDataA), 64'({CH{expWord}}));
    @(posedge clk);
    #1;
  endtask

  task automatic waitSad(input string name, input logic [63:0] expA, input logic [63:0] expB);
    bit seen;
    seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clk);
      if (sadValidA) seen = 1;
    end
    checkOutput({name, "Pulse"}, 64'(seen), 64'd1);
    if (seen) begin
      checkOutput(name, 64'(sadA), expA);
      checkOutput({name, "Sat"}, 64'(sadB), expB);
      @(negedge clk);
      checkOutput({name, "Single"}, 64'(sadValidA), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutValid", 64'(outValidA), 64'd0);
    checkOutput("resetSad", 64'(sadA), 64'd0);
    rst = 1'b0;

    directedBeat(8'd200, 8'd50,  2'd0, 1'b0, 9'h096);
    directedBeat(8'd50,  8'd200, 2'd0, 1'b0, 9'h196);
    directedBeat(8'd77,  8'd77,  2'd0, 1'b0, 9'h000);
    directedBeat(8'd0,   8'd255, 2'd0, 1'b0, 9'h1FF);
    directedBeat(8'd50,  8'd200, 2'd1, 1'b0, 9'h000);
    directedBeat(8'd50,  8'd200, 2'd2, 1'b0, 9'h096);
    directedBeat(8'd50,  8'd200, 2'd3, 1'b1, 9'h196);
    waitSad("sadDirected", 64'd3015, 64'd1023);

    applyStimulus(8'd30,  8'd20,  2'd0, 1'b0);
    applyStimulus(8'd20,  8'd30,  2'd1, 1'b0);
    applyStimulus(8'd110, 8'd100, 2'd2, 1'b0);
    applyStimulus(8'd5,   8'd15,  2'd3, 1'b1);
    waitSad("sadFourBeats", 64'd120, 64'd120);

    applyStimulus(8'd9, 8'd4, 2'd0, 1'b0);
    applyStimulus(8'd4, 8'd9, 2'd0, 1'b1);
    waitSad("sadFreshGroup", 64'd30, 64'd30);

    applyStimulus(8'd255, 8'd0, 2'd0, 1'b0);
    applyStimulus(8'd255, 8'd0, 2'd0, 1'b0);
    applyStimulus(8'd255, 8'd0, 2'd0, 1'b1);
    waitSad("sadSaturate", 64'd2295, 64'd1023);

    applyStimulus(8'd60, 8'd40, 2'd0, 1'b0);
    applyStimulus(8'd60, 8'd40, 2'd0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("flushOutValid", 64'(outValidA), 64'd0);
    checkOutput("flushSad", 64'(sadA), 64'd0);
    checkOutput("flushSadSat", 64'(sadB), 64'd0);
    checkOutput("flushSadValid", 64'(sadValidA), 64'd0);
    @(negedge clk);
    checkOutput("flushStageOne", 64'(outValidA), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(8'd20, 8'd13, 2'd0, 1'b1);
    waitSad("sadAfterReset", 64'd21, 64'd21);

    for (int i = 0; i < 600; i++) begin
      inValid  = ($urandom_range(3) != 0);
      outReady = ($urandom_range(2) != 0);
      aIn      = 24'($urandom);
      bIn      = ($urandom_range(7) == 0) ? aIn : 24'($urandom);
      modeIn   = 2'($urandom);
      inLast   = ($urandom_range(4) == 0);
      rst      = (i == 300);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    inValid  = 1'b0;
    inLast   = 1'b0;
    outReady = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("drainedOutValid", 64'(outValidA), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/diff_sm_pipe.md
Name: diff_sm_pipe

Overview:
- Multi-channel, parametrised signed-magnitude subtractor for the ZOOM datapath.
- Computes per-channel a-b on packed pixel streams (e.g. RGB) through a 2-stage valid/ready pipeline.
- Output encoding is selectable per beat.
- Also accumulates a per-line/per-block sum of absolute differences (SAD), released on a `last` marker. The SAD feeds interpolation-weight and motion checks.

Parameters:
- WIDTH, 8, unsigned bits per channel.
- CH, 3, channel count packed in a/b; channel k occupies bits [k*WIDTH +: WIDTH].
- SAD_W, 24, SAD accumulator width; saturating.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  output encoding, sampled with each accepted beat. 0 = sign-magnitude, 1 = saturating a-b, 2 = absolute difference, 3 = treated as 0.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat.
- in_last  in  1  final beat of a SAD group.
- a  in  CH*WIDTH  minuend channels, unsigned.
- b  in  CH*WIDTH  subtrahend channels, unsigned.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  in_last delayed with its beat.
- out_data  out  CH*(WIDTH+1)  channel k at [k*(WIDTH+1) +: WIDTH+1]; bit WIDTH is the sign/flag bit.
- sad_valid  out  1  one-cycle pulse when sad is updated.
- sad  out  SAD_W  SAD of the completed group; held until the next update.

Behaviour:
- Every register updates on the rising edge of clk. All state below is synchronous to clk.
- Reset:
  - Applies in the cycle rst=1.
  - Clears out_valid, out_last, out_data, sad_valid, sad, the internal accumulator and the stage-1 valid.
  - in_ready is 0 while rst=1.
  - In-flight beats are discarded. The next post-reset beat starts a fresh SAD group.
- Pipeline control:
  - Advance enable en = !out_valid || out_ready.
  - in_ready = en (when not in reset).
  - Beat accepted when in_valid && in_ready.
  - Stage 1 registers the per-channel raw difference d = a + ~b + 1 (WIDTH+1 bits, two's complement), plus mode and last.
  - Stage 2 registers the encoded result.
  - Latency is 2 cycles with out_ready held at 1, at full throughput of 1 beat/cycle.
  - With out_ready=0 and out_valid=1, both stages hold. out_data, out_last and out_valid must stay stable until transfer.
  - Bubbles propagate as invalid stages.
- Per-channel arithmetic (m = |a-b|, neg = a<b):
  - m is computed as d[WIDTH] ? ~(a + ~b) : d[WIDTH-1:0].
  - Mode 0: {neg, m}. When a==b the result is all zeros; negative zero is never produced.
  - Mode 1: {0, neg ? 0 : m}.
  - Mode 2: {0, m}.
  - Mode 3: identical to mode 0.
- Mode is captured per beat at acceptance. Changing mode mid-stream affects only later beats.
- SAD:
  - beat_sum = sum over channels of m (width WIDTH + clog2(CH)), computed in stage 2.
  - On each output transfer (out_valid && out_ready):
    - out_last=0: acc <= sat(acc + beat_sum).
    - out_last=1: sad <= sat(acc + beat_sum), sad_valid=1 for that one cycle, acc <= 0.
  - sat() clamps to 2^SAD_W-1.
  - SAD always uses |a-b|, independent of mode.
  - A group of one beat (in_last on its first beat) is legal.
- sad_valid is 0 in every cycle without a last transfer.

Decomposition:
- Package diff_pkg holds:
  - mode constants MODE_SM=2'd0, MODE_SAT=2'd1, MODE_ABS=2'd2;
  - a function for the SAD beat-sum width.
- Sub-module diff_sm_lane (parameter WIDTH) is combinational: from a, b, mode it produces neg, m and the encoded WIDTH+1 word. It is instantiated CH times via generate.
- Pipeline registers and the SAD accumulator live in diff_sm_pipe.

Test Plan:
- Encoding, defaults, mode 0:
  - a ch0=200, b ch0=50 -> ch0 = 9'h096.
  - a=50, b=200 -> 9'h196.
  - a=b=77 -> 9'h000.
  - a=0, b=255 -> 9'h1FF.
  - Each result appears exactly 2 cycles after acceptance.
- Modes: a=50, b=200 -> mode 1 gives 9'h000, mode 2 gives 9'h096, mode 3 gives 9'h196. Alternate the mode every beat and check each output matches its own beat's mode.
- Backpressure: stream 8 beats with out_ready toggling randomly -> no loss or duplication, in-order data, outputs stable while stalled, in_ready=0 only when out_valid && !out_ready.
- SAD:
  - 4 beats of CH=3, each channel |a-b|=10, last on beat 4 -> sad=120 with a single sad_valid pulse on the beat-4 transfer.
  - The next group starts from 0.
- Saturation: SAD_W=10, 3 beats with all channels a=255, b=0 (beat_sum 765), last on beat 3 -> sad=1023.
- Reset: assert rst for 1 cycle while 2 beats are in flight -> the next cycle shows out_valid=0, sad=0, sad_valid=0. Those beats never appear, and the next group's SAD excludes them.
